// File: rtl/vga_timing_gen_prog.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_prog
// Programmable VGA-style sync generator. Divides clk down to a pixel tick,
// runs x/y counters and decodes hsync/vsync/video from the active timing.
// A new timing set is loaded through a valid/ready port into a shadow register
// and becomes active only at the frame boundary. Sync/video can be delayed by
// PIPE_DLY pixel ticks to line up with a downstream pixel pipeline.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    config handshake (ready low while a config pends)
//   cfg_h_* / cfg_v_*        requested horizontal / vertical timing
//   cfg_hs_pol / cfg_vs_pol  requested sync polarity (1 = active-high)
//   cfg_err                  one-clk pulse when an accepted config is invalid
//   pix_tick                 pixel enable
//   pix_x, pix_y             current column / row (never delayed)
//   hsync, vsync, video      decoded outputs (delayed PIPE_DLY ticks)
//   line_start, frame_start  strobes for x==0 / x==0&&y==0 on a pixel tick
// -----------------------------------------------------------------------------
module vga_timing_gen_prog #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_PULSE  = 96,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_PULSE  = 2,
    parameter int unsigned V_TOTAL  = 525,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_h_disp,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_pulse,
    input  logic [CNT_W-1:0] cfg_h_total,
    input  logic [CNT_W-1:0] cfg_v_disp,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_pulse,
    input  logic [CNT_W-1:0] cfg_v_total,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    output logic             cfg_err,
    output logic             pix_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
    // Extra headroom so disp+fp+pulse can never wrap during checks/decode.
    localparam int unsigned EW = CNT_W + 2;

    typedef struct packed {
        logic [CNT_W-1:0] h_disp;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_pulse;
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] v_disp;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_pulse;
        logic [CNT_W-1:0] v_total;
        logic             hs_pol;
        logic             vs_pol;
    } cfg_t;

    localparam cfg_t CfgRst = '{
        h_disp:  CNT_W'(H_DISP),
        h_fp:    CNT_W'(H_FP),
        h_pulse: CNT_W'(H_PULSE),
        h_total: CNT_W'(H_TOTAL),
        v_disp:  CNT_W'(V_DISP),
        v_fp:    CNT_W'(V_FP),
        v_pulse: CNT_W'(V_PULSE),
        v_total: CNT_W'(V_TOTAL),
        hs_pol:  HS_POL,
        vs_pol:  VS_POL
    };

    logic [DivW-1:0]  div_q;
    logic [CNT_W-1:0] x_q, y_q;
    cfg_t             act_q, shd_q, cfg_in;
    logic             pending_q, cfg_err_q;

    logic             x_last, y_last, apply, accept, cfg_ok;
    logic [EW-1:0]    h_sum_in, v_sum_in;
    logic [EW-1:0]    h_beg, h_end, v_beg, v_end, x_ext, y_ext;
    logic             hs_act, vs_act, vid_raw, hs_lvl, vs_lvl;

    assign cfg_in = '{
        h_disp:  cfg_h_disp,
        h_fp:    cfg_h_fp,
        h_pulse: cfg_h_pulse,
        h_total: cfg_h_total,
        v_disp:  cfg_v_disp,
        v_fp:    cfg_v_fp,
        v_pulse: cfg_v_pulse,
        v_total: cfg_v_total,
        hs_pol:  cfg_hs_pol,
        vs_pol:  cfg_vs_pol
    };

    // ---------------- divider ----------------
    assign pix_tick = (div_q == DivMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (pix_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    // ---------------- counters ----------------
    assign x_last = (x_q == act_q.h_total - CNT_W'(1));
    assign y_last = (y_q == act_q.v_total - CNT_W'(1));
    // Shadow is swapped in on the same edge the counters wrap to (0,0).
    assign apply  = pix_tick && x_last && y_last && pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (pix_tick) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : y_q + CNT_W'(1);
            end else begin
                x_q <= x_q + CNT_W'(1);
            end
        end
    end

    // ---------------- config handshake ----------------
    assign cfg_ready = ~pending_q;
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        h_sum_in = {2'b00, cfg_h_disp} + {2'b00, cfg_h_fp} + {2'b00, cfg_h_pulse};
        v_sum_in = {2'b00, cfg_v_disp} + {2'b00, cfg_v_fp} + {2'b00, cfg_v_pulse};
        cfg_ok   = (cfg_h_disp != '0) && (cfg_h_pulse != '0) &&
                   (h_sum_in <= {2'b00, cfg_h_total}) &&
                   (cfg_v_disp != '0) && (cfg_v_pulse != '0) &&
                   (v_sum_in <= {2'b00, cfg_v_total});
    end

    // accept needs !pending and apply needs pending, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q     <= CfgRst;
            shd_q     <= CfgRst;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= accept && !cfg_ok;
            if (accept && cfg_ok) begin
                shd_q     <= cfg_in;
                pending_q <= 1'b1;
            end else if (apply) begin
                act_q     <= shd_q;
                pending_q <= 1'b0;
            end
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        x_ext   = {2'b00, x_q};
        y_ext   = {2'b00, y_q};
        h_beg   = {2'b00, act_q.h_disp} + {2'b00, act_q.h_fp};
        h_end   = h_beg + {2'b00, act_q.h_pulse};
        v_beg   = {2'b00, act_q.v_disp} + {2'b00, act_q.v_fp};
        v_end   = v_beg + {2'b00, act_q.v_pulse};
        hs_act  = (x_ext >= h_beg) && (x_ext < h_end);
        vs_act  = (y_ext >= v_beg) && (y_ext < v_end);
        vid_raw = (x_q < act_q.h_disp) && (y_q < act_q.v_disp);
        hs_lvl  = hs_act ? act_q.hs_pol : ~act_q.hs_pol;
        vs_lvl  = vs_act ? act_q.vs_pol : ~act_q.vs_pol;
    end

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign line_start  = pix_tick && (x_q == '0);
    assign frame_start = pix_tick && (x_q == '0) && (y_q == '0);

    // ---------------- output delay ----------------
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hsync = hs_lvl;
            assign vsync = vs_lvl;
            assign video = vid_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_sr_q, vs_sr_q, vid_sr_q;

            // Not flushed on a config swap: old-mode samples drain naturally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hs_sr_q  <= {PIPE_DLY{~HS_POL}};
                    vs_sr_q  <= {PIPE_DLY{~VS_POL}};
                    vid_sr_q <= '0;
                end else if (pix_tick) begin
                    hs_sr_q[0]  <= hs_lvl;
                    vs_sr_q[0]  <= vs_lvl;
                    vid_sr_q[0] <= vid_raw;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_sr_q[i]  <= hs_sr_q[i-1];
                        vs_sr_q[i]  <= vs_sr_q[i-1];
                        vid_sr_q[i] <= vid_sr_q[i-1];
                    end
                end
            end

            assign hsync = hs_sr_q[PIPE_DLY-1];
            assign vsync = vs_sr_q[PIPE_DLY-1];
            assign video = vid_sr_q[PIPE_DLY-1];
        end
    endgenerate

endmodule
